conv_stream_ctrl: RTL
=====================

// Module: conv_stream_ctrl
// PURPOSE
//  Sequencer for one convolver pass: on start, latches the kernel, clears the convolver, then streams n*n
//  activations from a 1-cycle-latency activation RAM into the convolver (raster order) with conv_ce aligned
//  to data. Collects valid_conv results into an output buffer at sequential addresses; signals done.
//  Sits between the layer scheduler (start/done) and one convolver + its activation/output memories.
// PARAMETERS
//  N          16     data width (fixed point, Q fractional bits)
//  Q          12     fractional bits (pass-through to convolver, unused arithmetically here)
//  n          4      input feature-map side
//  k          3      kernel side
//  s          1      stride
//  AW         8      activation/output address width; must satisfy 2**AW >= n*n
//  DRAIN_MAX  64     watchdog: max cycles in DRAIN without a valid_conv before abort
// PORTS
//  clk            in   1        clock
//  global_rst     in   1        synchronous active-high reset
//  start          in   1        1-cycle request; accepted only in IDLE
//  hold           in   1        pause streaming (reads and conv_ce low) while high
//  weight_in      in   k*k*N    kernel, sampled on accepted start
//  busy           out  1        high from accepted start until done cycle inclusive
//  done           out  1        1-cycle pulse at end of pass
//  err            out  1        sticky until next accepted start: watchdog abort or output overcount
//  act_rd_en      out  1        activation RAM read strobe
//  act_rd_addr    out  AW       activation read address
//  act_rd_data    in   N        read data, valid the cycle after act_rd_en
//  conv_rst       out  1        convolver reset (drives its global_rst)
//  conv_ce        out  1        convolver clock enable
//  conv_activation out N        convolver activation input
//  conv_weight    out  k*k*N    latched kernel
//  conv_op        in   N        convolver result
//  valid_conv     in   1        convolver result valid
//  end_conv       in   1        convolver last-result flag
//  out_wr_en      out  1        output buffer write strobe
//  out_wr_addr    out  AW       output address
//  out_wr_data    out  N        output data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except conv_rst=1 during reset; counters 0; conv_weight 0.
//  - OUT_CNT = ((n-k)/s+1)**2 (integer divide), computed as localparam.
//  - IDLE: start -> CLR, latch weight_in, clear err/counters, busy=1.
//  - CLR: conv_rst=1 for exactly one cycle -> STREAM.
//  - STREAM: each cycle with hold=0: act_rd_en=1, act_rd_addr=rd_cnt, rd_cnt++. Issuing addr n*n-1 -> DRAIN.
//    conv_ce and conv_activation are act_rd_en/act_rd_data delayed one cycle (registered en, data direct).
//    hold=1: no read issued; conv_ce low the following cycle; resumes at same address.
//  - DRAIN: conv_ce=1 with conv_activation=0 (hold respected) until wr_cnt==OUT_CNT -> DONE.
//    Watchdog counts DRAIN cycles without valid_conv; reaching DRAIN_MAX sets err -> DONE.
//  - Any state: valid_conv & conv_ce-cycle -> out_wr_en=1, out_wr_addr=wr_cnt, wr_cnt++ (registered, 1-cycle
//    latency). valid_conv when wr_cnt==OUT_CNT: not written, err=1. end_conv informational only.
//  - DONE: done=1 one cycle, busy=1 that cycle -> IDLE. conv_ce=0.
//  - start while busy ignored. global_rst mid-pass: immediate IDLE, no done, partial writes stand.
//  - Counters width AW; rd_cnt never wraps (stops at n*n-1).
// CONFIGURATION
//  - RELU_OUT_EN defined: out_wr_data = conv_op[N-1] ? 0 : conv_op (ReLU applied before write).
//  - RELU_OUT_EN undefined: out_wr_data = conv_op unmodified. Timing identical in both.
// STRUCTURE
//  - Package conv_pkg: state enum (IDLE, CLR, STREAM, DRAIN, DONE), out_count(n,k,s) function.
//  - One sub-module: conv_addr_gen (rd_cnt/wr_cnt counters with enable, terminal flags).
//  - Convolver instantiated outside; this block drives its ports only.
// TESTING
//  - Default params, RAM[i]=i, weight 144'h0008_0007_0006_0005_0004_0003_0002_0001_0000, start ->
//    reads addr 0..15 consecutive, conv_rst one cycle, 4 writes addr 0..3 matching golden, done 1 cycle, err=0.
//  - hold high 3 cycles at rd_cnt=5 -> addr 5 re-issued after hold, conv_ce gap 3 cycles, results unchanged.
//  - start pulsed during STREAM -> ignored, single done, exactly 4 writes.
//  - global_rst at rd_cnt=8 -> next cycle IDLE, busy=0, no done; new start completes normally.
//  - Convolver model withholding valid_conv -> err=1 after 64 DRAIN cycles, done pulses, busy drops.
//  - RELU_OUT_EN build, negative weights -> negative conv_op written as 0; positive results unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolver stream controller.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // Number of output pixels produced by a k x k kernel over an n x n map at stride s.
    function automatic int out_count(input int n, input int k, input int s);
        return ((n - k) / s + 1) * ((n - k) / s + 1);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Activation read counter and output write counter with terminal flags.
module conv_addr_gen #(
    parameter int AW      = 8,
    parameter int RD_LAST = 15,
    parameter int WR_MAX  = 4
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          clr,
    input  logic          rd_inc,
    input  logic          wr_inc,
    output logic [AW-1:0] rd_cnt,
    output logic [AW-1:0] wr_cnt,
    output logic          rd_last,
    output logic          wr_full
);

    assign rd_last = (rd_cnt == AW'(RD_LAST));
    assign wr_full = (wr_cnt == AW'(WR_MAX));

    // Both counters saturate at their terminal value instead of wrapping.
    always_ff @(posedge clk) begin
        if (global_rst || clr) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_inc && !rd_last) rd_cnt <= rd_cnt + 1'b1;
            if (wr_inc && !wr_full) wr_cnt <= wr_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Sequencer for one convolver pass: clear, stream n*n activations, drain, collect results.
// Optional build macro RELU_OUT_EN clamps negative results to zero before they are written.
module conv_stream_ctrl
    import conv_pkg::*;
#(
    parameter int N         = 16,
    parameter int Q         = 12,
    parameter int n         = 4,
    parameter int k         = 3,
    parameter int s         = 1,
    parameter int AW        = 8,
    parameter int DRAIN_MAX = 64
) (
    input  logic             clk,
    input  logic             global_rst,
    input  logic             start,
    input  logic             hold,
    input  logic [k*k*N-1:0] weight_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             act_rd_en,
    output logic [AW-1:0]    act_rd_addr,
    input  logic [N-1:0]     act_rd_data,
    output logic             conv_rst,
    output logic             conv_ce,
    output logic [N-1:0]     conv_activation,
    output logic [k*k*N-1:0] conv_weight,
    input  logic [N-1:0]     conv_op,
    input  logic             valid_conv,
    input  logic             end_conv,
    output logic             out_wr_en,
    output logic [AW-1:0]    out_wr_addr,
    output logic [N-1:0]     out_wr_data
);

    localparam int OUT_CNT = out_count(n, k, s);
    localparam int RD_LAST = n * n - 1;
    localparam int WDW     = $clog2(DRAIN_MAX + 1);
    localparam int q_frac_unused = Q;

    state_t          state;
    logic [AW-1:0]   rd_cnt;
    logic [AW-1:0]   wr_cnt;
    logic            rd_last;
    logic            wr_full;
    logic            cnt_clr;
    logic            wr_take;
    logic            rd_phase;
    logic            wd_hit;
    logic            drain_exit;
    logic            ce_next;
    logic [WDW-1:0]  wd_cnt;
    logic [N-1:0]    wr_data_next;
    logic            end_conv_unused;

    assign end_conv_unused = end_conv;

    assign act_rd_en       = (state == STREAM) && !hold;
    assign act_rd_addr     = rd_cnt;
    assign conv_activation = rd_phase ? act_rd_data : '0;
    assign cnt_clr         = (state == IDLE) && start;
    assign wr_take         = valid_conv && conv_ce && !wr_full;
    assign wd_hit          = !valid_conv && (wd_cnt == WDW'(DRAIN_MAX - 1));
    assign drain_exit      = wr_full || wd_hit;
    assign ce_next         = act_rd_en || ((state == DRAIN) && !hold && !drain_exit);

`ifdef RELU_OUT_EN
    assign wr_data_next = conv_op[N-1] ? '0 : conv_op;
`else
    assign wr_data_next = conv_op;
`endif

    conv_addr_gen #(
        .AW     (AW),
        .RD_LAST(RD_LAST),
        .WR_MAX (OUT_CNT)
    ) u_addr_gen (
        .clk       (clk),
        .global_rst(global_rst),
        .clr       (cnt_clr),
        .rd_inc    (act_rd_en),
        .wr_inc    (wr_take),
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
        .rd_last   (rd_last),
        .wr_full   (wr_full)
    );

    // conv_ce trails the read strobe by one cycle so it lines up with RAM data.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            conv_rst    <= 1'b1;
            conv_ce     <= 1'b0;
            rd_phase    <= 1'b0;
            conv_weight <= '0;
            wd_cnt      <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
        end else begin
            conv_ce   <= ce_next;
            rd_phase  <= act_rd_en;
            out_wr_en <= wr_take;
            done      <= 1'b0;
            conv_rst  <= 1'b0;
            if (wr_take) begin
                out_wr_addr <= wr_cnt;
                out_wr_data <= wr_data_next;
            end
            if (valid_conv && conv_ce && wr_full) err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= CLR;
                        conv_weight <= weight_in;
                        err         <= 1'b0;
                        wd_cnt      <= '0;
                        busy        <= 1'b1;
                        conv_rst    <= 1'b1;
                    end
                end
                CLR: state <= STREAM;
                STREAM: begin
                    if (act_rd_en && rd_last) state <= DRAIN;
                end
                DRAIN: begin
                    wd_cnt <= valid_conv ? '0 : wd_cnt + 1'b1;
                    if (wr_full) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (wd_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
